// File: rtl/xg_tx_frame_arbiter.sv
// rtl/xg_tx_frame_arbiter.sv - frame-atomic round-robin arbiter for the 64-bit XGMII MAC TX stream
module xg_tx_frame_arbiter #(
    parameter int N_SRC      = 4,
    parameter int IFG_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N_SRC-1:0]     s_tvalid,
    output logic [N_SRC-1:0]     s_tready,
    input  logic [64*N_SRC-1:0]  s_tdata,
    input  logic [8*N_SRC-1:0]   s_tkeep,
    input  logic [N_SRC-1:0]     s_tlast,
    input  logic [N_SRC-1:0]     s_tuser,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [63:0]          m_tdata,
    output logic [7:0]           m_tkeep,
    output logic                 m_tlast,
    output logic                 m_tuser,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic [CNT_W-1:0]     frame_cnt
);

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  last_grant;
    logic [3:0]  gap_cnt;

    logic        pick_hi_found;
    logic [2:0]  pick_hi_id;
    logic        pick_lo_found;
    logic [2:0]  pick_lo_id;
    logic        pick_found;
    logic [2:0]  pick_id;

    logic        sel_tvalid;
    logic [63:0] sel_tdata;
    logic [7:0]  sel_tkeep;
    logic        sel_tlast;
    logic        sel_tuser;

    logic        grant_now;
    logic        frame_done;

    // Round robin: the lowest index above last_grant wins; otherwise wrap to
    // the lowest index at or below it. Scanning downward leaves the lowest hit.
    always_comb begin
        pick_hi_found = 1'b0;
        pick_hi_id    = '0;
        pick_lo_found = 1'b0;
        pick_lo_id    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (s_tvalid[i]) begin
                if (3'(i) > last_grant) begin
                    pick_hi_found = 1'b1;
                    pick_hi_id    = 3'(i);
                end else begin
                    pick_lo_found = 1'b1;
                    pick_lo_id    = 3'(i);
                end
            end
        end
        pick_found = pick_hi_found | pick_lo_found;
        pick_id    = pick_hi_found ? pick_hi_id : pick_lo_id;
    end

    always_comb begin
        sel_tvalid = 1'b0;
        sel_tdata  = '0;
        sel_tkeep  = '0;
        sel_tlast  = 1'b0;
        sel_tuser  = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_id == 3'(i)) begin
                sel_tvalid = s_tvalid[i];
                sel_tdata  = s_tdata[64*i +: 64];
                sel_tkeep  = s_tkeep[8*i +: 8];
                sel_tlast  = s_tlast[i];
                sel_tuser  = s_tuser[i];
            end
        end
    end

    assign grant_now  = (state == ARB) && en && pick_found;
    assign frame_done = (state == XFER) && sel_tvalid && m_tready && sel_tlast;

    always_comb begin
        state_nxt = state;
        m_tvalid  = 1'b0;
        s_tready  = '0;
        case (state)
            ARB: begin
                if (grant_now) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                m_tvalid = sel_tvalid;
                for (int i = 0; i < N_SRC; i++) begin
                    s_tready[i] = (grant_id == 3'(i)) && m_tready;
                end
                if (frame_done) begin
                    state_nxt = (IFG_CYCLES > 0) ? GAP : ARB;
                end
            end
            GAP: begin
                if (gap_cnt <= 4'd1) begin
                    state_nxt = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    // Data lanes are steered but not gated; consumers qualify with m_tvalid.
    assign m_tdata = sel_tdata;
    assign m_tkeep = sel_tkeep;
    assign m_tlast = sel_tlast;
    assign m_tuser = sel_tuser;
    assign busy    = (state != ARB);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            grant_id   <= '0;
            last_grant <= 3'(N_SRC - 1);
            gap_cnt    <= '0;
            frame_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (grant_now) begin
                grant_id   <= pick_id;
                last_grant <= pick_id;
            end
            if (frame_done) begin
                frame_cnt <= frame_cnt + 1'b1;
                gap_cnt   <= 4'(IFG_CYCLES);
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_xg_tx_frame_arbiter.sv
// tb/tb_xg_tx_frame_arbiter.sv - randomized self-checking bench for xg_tx_frame_arbiter
module tb_xg_tx_frame_arbiter;

    localparam int N   = 4;
    localparam int IFG = 2;
    localparam int CW  = 8;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic m_tready;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [64*N-1:0] s_tdata;
    logic [8*N-1:0]  s_tkeep;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tuser;
    logic            m_tvalid;
    logic [63:0]     m_tdata;
    logic [7:0]      m_tkeep;
    logic            m_tlast;
    logic            m_tuser;
    logic [2:0]      grant_id;
    logic            busy;
    logic [CW-1:0]   frame_cnt;

    always #5 clk = ~clk;

    xg_tx_frame_arbiter #(.N_SRC(N), .IFG_CYCLES(IFG), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .grant_id(grant_id), .busy(busy), .frame_cnt(frame_cnt)
    );

    // Per-source driver state
    logic        v_q [N];
    logic [63:0] d_q [N];
    logic [7:0]  k_q [N];
    logic        l_q [N];
    logic        u_q [N];
    logic        rdy [N];
    logic        fire [N];
    int          left [N];
    int          wait_c [N];
    int          fno [N];
    int          beat [N];
    logic        fu [N];
    bit          one_beat;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign s_tvalid[g]           = v_q[g];
        assign s_tdata[64*g +: 64]   = d_q[g];
        assign s_tkeep[8*g +: 8]     = k_q[g];
        assign s_tlast[g]            = l_q[g];
        assign s_tuser[g]            = u_q[g];
        assign rdy[g]                = s_tready[g];
    end

    // Reference model: who owns the link, who sent last, idle clocks still owed
    int  m_owner;
    int  m_last;
    int  m_cool;
    int  m_grant;
    int  m_frames;
    bit  model_ok;

    int  n_checks;
    int  n_fail;
    int  cyc;
    int  last_end;
    bit  mid_frame;
    bit  exact_gap;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic new_beat(input int i);
        d_q[i] = {8'(i), 16'(fno[i]), 16'(beat[i]), 24'($urandom)};
        l_q[i] = (left[i] == 1);
        k_q[i] = l_q[i] ? (8'hFF >> $urandom_range(0, 7)) : 8'hFF;
        u_q[i] = fu[i];
    endtask

    task automatic drive_step();
        for (int i = 0; i < N; i++) begin
            if (left[i] > 0 && fire[i]) begin
                left[i]--;
                beat[i]++;
                if (left[i] == 0) begin
                    v_q[i]    = 1'b0;
                    wait_c[i] = one_beat ? 0 : $urandom_range(0, 6);
                end else begin
                    new_beat(i);
                    if (!one_beat && $urandom_range(0, 3) == 0) v_q[i] = 1'b0;
                end
            end else if (left[i] > 0 && !v_q[i]) begin
                v_q[i] = 1'b1;
            end
            if (left[i] == 0) begin
                if (wait_c[i] > 0) begin
                    wait_c[i]--;
                end else begin
                    left[i] = one_beat ? 1 : $urandom_range(1, 8);
                    beat[i] = 0;
                    fno[i]++;
                    fu[i]   = ($urandom_range(0, 7) == 0);
                    v_q[i]  = 1'b1;
                    new_beat(i);
                end
            end
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_owner  = -1;
            m_last   = N - 1;
            m_cool   = 0;
            m_grant  = 0;
            m_frames = 0;
            model_ok = 1'b1;
        end else if (m_owner >= 0) begin
            if (v_q[m_owner] && m_tready && l_q[m_owner]) begin
                m_frames = (m_frames + 1) % (1 << CW);
                m_owner  = -1;
                m_cool   = IFG;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (en) begin
            for (int d = 1; d <= N; d++) begin
                int j;
                j = (m_last + d) % N;
                if (m_owner < 0 && v_q[j]) m_owner = j;
            end
            if (m_owner >= 0) begin
                m_last  = m_owner;
                m_grant = m_owner;
            end
        end
    endtask

    task automatic check_outputs();
        logic          exp_v;
        logic [N-1:0]  exp_r;
        exp_v = 1'b0;
        exp_r = '0;
        if (m_owner >= 0) begin
            exp_v = v_q[m_owner];
            if (m_tready) exp_r[m_owner] = 1'b1;
        end
        chk("m_tvalid", 64'(m_tvalid), 64'(exp_v));
        chk("s_tready", 64'(s_tready), 64'(exp_r));
        chk("busy", 64'(busy), 64'((m_owner >= 0) || (m_cool > 0)));
        chk("grant_id", 64'(grant_id), 64'(m_grant));
        chk("frame_cnt", 64'(frame_cnt), 64'(m_frames));
        if (exp_v) begin
            chk("m_tdata", m_tdata, d_q[m_owner]);
            chk("m_tkeep", 64'(m_tkeep), 64'(k_q[m_owner]));
            chk("m_tlast", 64'(m_tlast), 64'(l_q[m_owner]));
            chk("m_tuser", 64'(m_tuser), 64'(u_q[m_owner]));
        end
        if (rst) begin
            mid_frame = 1'b0;
            last_end  = -1;
        end else if (m_tvalid && m_tready) begin
            if (!mid_frame && last_end >= 0) begin
                if (exact_gap) chk("ifg_exact", 64'(cyc - last_end - 1), 64'(IFG + 1));
                else           chk("ifg_min", 64'((cyc - last_end - 1) >= IFG + 1), 64'd1);
            end
            mid_frame = !m_tlast;
            if (m_tlast) last_end = cyc;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (model_ok) check_outputs();
        for (int i = 0; i < N; i++) fire[i] = v_q[i] && rdy[i];
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        drive_step();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        last_end  = -1;
        mid_frame = 1'b0;
        exact_gap = 1'b0;
        model_ok  = 1'b0;
        one_beat  = 1'b0;
        m_owner   = -1;
        m_last    = N - 1;
        m_cool    = 0;
        m_grant   = 0;
        m_frames  = 0;
        rst       = 1'b1;
        en        = 1'b1;
        m_tready  = 1'b1;
        for (int i = 0; i < N; i++) begin
            v_q[i] = 1'b0; d_q[i] = '0; k_q[i] = '0; l_q[i] = 1'b0; u_q[i] = 1'b0;
            fire[i] = 1'b0; left[i] = 0; fno[i] = 0; beat[i] = 0; fu[i] = 1'b0;
            wait_c[i] = $urandom_range(2, 10);
        end

        repeat (3) cycle();
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        rst = 1'b0;

        for (int c = 0; c < 4000; c++) begin
            rst = (m_owner >= 0 && $urandom_range(0, 199) == 0);
            if ($urandom_range(0, 29) == 0) en = ~en;
            m_tready = ($urandom_range(0, 9) < 7);
            cycle();
        end

        rst      = 1'b0;
        en       = 1'b1;
        m_tready = 1'b1;
        one_beat = 1'b1;
        repeat (100) cycle();
        exact_gap = 1'b1;
        repeat (1200) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
